// File: rtl/mgt_01_booth_r4_seq_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package mgt_01_booth_r4_seq_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Operands are extended by two bits, so one extra Booth digit is needed.
    function automatic int booth_iter(input int xlen);
        return (xlen + 2) / 2;
    endfunction

endpackage

// File: rtl/mgt_01_booth_r4_seq_mul_digit.sv
// Radix-4 Booth digit recoder: {B[1:0], L} -> 0, +-A, +-2A as zero/neg/two flags.
module mgt_01_booth_r4_digit (
    input  logic [2:0] bits_i,
    output logic       zero_o,
    output logic       neg_o,
    output logic       two_o
);

    always_comb begin
        zero_o = (bits_i == 3'b000) || (bits_i == 3'b111);
        neg_o  = bits_i[2] && !zero_o;
        two_o  = (bits_i == 3'b011) || (bits_i == 3'b100);
    end

endmodule

// File: rtl/mgt_01_booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU, one digit per enabled cycle.
module mgt_01_booth_r4_seq_mul
    import mgt_01_booth_r4_seq_mul_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            kill_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] multiplicand_i,
    input  logic [XLEN-1:0] multiplier_i,
    input  logic [1:0]      op_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int ITER = booth_iter(XLEN);
    localparam int CW   = $clog2(ITER + 1);
    localparam int AW   = XLEN + 2;
    localparam int PW   = XLEN + 3;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mul_state_e      state_q, state_d;
    mul_op_e         op_q, op_d;
    logic [AW-1:0]   a_q, a_d;
    logic [AW-1:0]   b_q, b_d;
    logic            l_q, l_d;
    logic [PW-1:0]   p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            dig_zero, dig_neg, dig_two;
    logic [PW-1:0]   addend, p_sum, p_step;
    logic [AW-1:0]   b_step;
    logic [AW-1:0]   a_ext, b_ext;
    logic [XLEN-1:0] sel_result;
    mul_op_e         op_in;
    logic            a_signed, b_signed;

    mgt_01_booth_r4_digit u_digit (
        .bits_i ({b_q[1:0], l_q}),
        .zero_o (dig_zero),
        .neg_o  (dig_neg),
        .two_o  (dig_two)
    );

    // Booth step: accumulate the recoded digit, then shift {P, B, L} right by two.
    always_comb begin
        addend = dig_two ? {a_q, 1'b0} : {a_q[AW-1], a_q};
        if (dig_zero) begin
            addend = '0;
        end
        p_sum  = dig_neg ? (p_q - addend) : (p_q + addend);
        p_step = {{2{p_sum[PW-1]}}, p_sum[PW-1:2]};
        b_step = {p_sum[1:0], b_q[AW-1:2]};
        // Product of the final step is {p_step[AW-1:0], b_step}; only its low 2*XLEN bits are exact.
        sel_result = (op_q == OP_MUL) ? b_step[XLEN-1:0]
                                      : {p_step[XLEN-3:0], b_step[AW-1:XLEN]};
    end

    always_comb begin
        op_in    = mul_op_e'(op_i);
        a_signed = (op_in != OP_MULHU);
        b_signed = (op_in == OP_MUL) || (op_in == OP_MULH);
        a_ext    = {{2{a_signed & multiplicand_i[XLEN-1]}}, multiplicand_i};
        b_ext    = {{2{b_signed & multiplier_i[XLEN-1]}}, multiplier_i};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        l_d      = l_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid_i && !kill_i) begin
                    op_d  = op_in;
                    a_d   = a_ext;
                    b_d   = b_ext;
                    l_d   = 1'b0;
                    p_d   = '0;
                    cnt_d = '0;
                    if (EARLY_ZERO && ((multiplicand_i == '0) || (multiplier_i == '0))) begin
                        state_d  = DONE;
                        result_d = '0;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    p_d   = p_step;
                    b_d   = b_step;
                    l_d   = b_q[1];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        result_d = sel_result;
                    end
                end
            end
            DONE: begin
                if (kill_i || ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            l_q      <= 1'b0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            l_q      <= l_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign busy_o   = (state_q != IDLE);
    assign result_o = result_q;

endmodule
